mem_stage_seq: RTL and testbench
================================

# mem_stage_seq

Memory-stage sequencer between the ALU→Mem pipeline buffer and the 16-bit-wide data memory. It decodes each memory-stage operation into one or two memory accesses and owns the stack pointer. It splits 32-bit PC pushes and pops (CALL/INT, RET/RTI) into two 16-bit accesses. While a two-access operation is in progress, it drives a stall so that upstream buffers hold their contents.

## Interface
Parameters:
- ADDR_W, 12, data-memory word-address width
- SP_RESET, 12'hFFF, stack pointer value after reset (top of memory)
- STACK_LIMIT, 12'h800, lowest legal stack address (used only with bounds check)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  operation in the memory stage is live
- i_flush  in  1  cancel the current op; honoured only in IDLE
- i_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH16, 4 POP16, 5 PUSH32, 6 POP32, 7 reserved (treated as NOP)
- i_alu  in  16  LOAD/STORE address (low ADDR_W bits used)
- i_read_data1  in  16  STORE/PUSH16 data
- i_pc  in  32  PUSH32 data
- i_mem_rdata  in  16  memory read data, asynchronous read of o_mem_addr
- o_mem_addr  out  ADDR_W  memory address
- o_mem_rd  out  1  read strobe
- o_mem_wr  out  1  write strobe, sampled by memory on posedge
- o_mem_wdata  out  16  write data
- o_rdata  out  16  LOAD/POP16 result, equal to i_mem_rdata in the access cycle
- o_pc  out  32  popped PC
- o_pc_valid  out  1  one-cycle pulse; o_pc is valid
- o_stall  out  1  hold upstream buffers and PC (drives their enable low)
- o_sp  out  ADDR_W  current stack pointer
- o_stack_exc  out  1  stack bound violation (only with SP_BOUNDS_CHECK_EN)

## Operation
- State machine: IDLE and SECOND.
- Registered state: state, sp, lo_half[15:0]. All other outputs are combinational from these registers and the inputs.
- The stack grows down. sp points to the next free word.
- An op is live when i_valid=1, i_flush=0 and state=IDLE.
- Live ops in IDLE:
  - LOAD: addr=i_alu, rd=1.
  - STORE: addr=i_alu, wr=1, wdata=i_read_data1.
  - PUSH16: addr=sp, wr=1, wdata=i_read_data1, sp←sp−1.
  - POP16: addr=sp+1, rd=1, sp←sp+1.
  - PUSH32: addr=sp, wr=1, wdata=i_pc[31:16], sp←sp−1, →SECOND, o_stall=1.
  - POP32: addr=sp+1, rd=1, lo_half←i_mem_rdata, sp←sp+1, →SECOND, o_stall=1.
- SECOND after PUSH32: addr=sp, wr=1, wdata=i_pc[15:0], sp←sp−1, →IDLE.
- SECOND after POP32: addr=sp+1, rd=1, o_pc={i_mem_rdata, lo_half}, o_pc_valid=1, sp←sp+1, →IDLE.
- A 1-bit op_is_pop register, set in IDLE, selects which SECOND behaviour applies.
- In SECOND, i_op, i_alu, i_read_data1 and i_pc are guaranteed held, because o_stall froze the buffer. i_valid and i_flush are ignored; the op always completes.
- NOP, reserved op, i_valid=0 or i_flush=1 in IDLE: rd=wr=0, no state change.
- sp arithmetic is modulo 2^ADDR_W (wraps silently without the bounds check). Address outputs are zero when rd=wr=0.

## Timing
- Reset values: state=IDLE, sp=SP_RESET, lo_half=0, op_is_pop=0.
- Outputs during reset: o_stall=0, o_pc_valid=0, o_mem_rd=o_mem_wr=0, o_mem_addr=0, o_mem_wdata=0, o_rdata=0, o_pc=0, o_stack_exc=0.
- Latency:
  - Single-access ops: 1 cycle, o_stall=0.
  - PUSH32/POP32: 2 cycles. o_stall=1 in the first cycle only.
  - o_pc_valid is asserted in the second cycle.
- Back-to-back two-access ops: the next op starts in the cycle after SECOND (no bubble).
- Reset mid-operation (in SECOND): returns to IDLE immediately and the second access is never issued. sp returns to SP_RESET and no o_pc_valid is produced.

## Configuration
- SP_BOUNDS_CHECK_EN defined:
  - Any push access with sp<STACK_LIMIT sets o_stack_exc=1 for that cycle and suppresses its write and sp update.
  - Any pop access with sp==SP_RESET sets o_stack_exc=1 for that cycle and suppresses its sp update.
  - A suppressed first half of PUSH32/POP32 still returns to IDLE with o_stall=0.
- Undefined: o_stack_exc is tied to 0 and sp wraps modulo 2^ADDR_W.

## Test plan
- Reset, then PUSH16 data 16'hA5A5 → write addr 12'hFFF, sp=12'hFFE; then POP16 → read addr 12'hFFF, o_rdata=16'hA5A5, sp=12'hFFF.
- PUSH32 with i_pc=32'h1234_5678 → cycle 1 writes 16'h1234 at 12'hFFF with o_stall=1; cycle 2 writes 16'h5678 at 12'hFFE with o_stall=0; sp=12'hFFD.
- POP32 following that push → reads 12'hFFE then 12'hFFF; o_pc=32'h1234_5678 with o_pc_valid=1 in cycle 2 only; sp=12'hFFF.
- LOAD at i_alu=16'h0010 with i_flush=1 → no rd strobe, sp unchanged; same op with i_flush=1 asserted in SECOND of a PUSH32 → second write still issued.
- rst asserted in SECOND of PUSH32 → no second write, sp=12'hFFF, state IDLE, o_stall=0 asynchronously.
- With SP_BOUNDS_CHECK_EN and sp forced to 12'h7FF via pushes → PUSH16 raises o_stack_exc, no write, sp unchanged; POP16 at sp=12'hFFF raises o_stack_exc.

Source files
------------

// File: rtl/mem_stage_seq.sv
// mem_stage_seq
//   Memory-stage sequencer between the ALU->Mem buffer and a 16-bit data
//   memory. Decodes each op into one or two memory accesses and owns the
//   stack pointer. 32-bit PC push/pop is split into two 16-bit accesses.
//   While the first access is issued, o_stall holds the upstream buffers.
//
//   Optional feature macro: SP_BOUNDS_CHECK_EN (stack bound exceptions).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_valid, i_flush  op is live / cancel op (only honoured in IDLE)
//   i_op              0 NOP 1 LOAD 2 STORE 3 PUSH16 4 POP16 5 PUSH32 6 POP32
//   i_alu             LOAD/STORE address
//   i_read_data1      STORE/PUSH16 data
//   i_pc              PUSH32 data
//   i_mem_rdata       async memory read data of o_mem_addr
//   o_mem_*           memory address / strobes / write data
//   o_rdata           LOAD/POP16 result
//   o_pc, o_pc_valid  popped PC and its one-cycle qualifier
//   o_stall           hold upstream buffers and PC
//   o_sp              current stack pointer
//   o_stack_exc       stack bound violation (0 unless SP_BOUNDS_CHECK_EN)

module mem_stage_seq #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] SP_RESET    = 12'hFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic [2:0]        i_op,
    input  logic [15:0]       i_alu,
    input  logic [15:0]       i_read_data1,
    input  logic [31:0]       i_pc,
    input  logic [15:0]       i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [15:0]       o_mem_wdata,
    output logic [15:0]       o_rdata,
    output logic [31:0]       o_pc,
    output logic              o_pc_valid,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_stack_exc
);

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_PUSH16 = 3'd3;
    localparam logic [2:0] OP_POP16  = 3'd4;
    localparam logic [2:0] OP_PUSH32 = 3'd5;
    localparam logic [2:0] OP_POP32  = 3'd6;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sp, sp_nxt;
    logic [15:0]       lo_half, lo_half_nxt;
    logic              op_is_pop, op_is_pop_nxt;

    logic [ADDR_W-1:0] sp_inc, sp_dec;
    logic              push_blk, pop_blk;
    logic              unused_bits;

    assign sp_inc = sp + ADDR_W'(1);
    assign sp_dec = sp - ADDR_W'(1);

`ifdef SP_BOUNDS_CHECK_EN
    assign push_blk = (sp < STACK_LIMIT);
    assign pop_blk  = (sp == SP_RESET);
`else
    assign push_blk = 1'b0;
    assign pop_blk  = 1'b0;
`endif

    assign unused_bits = ^{i_alu, STACK_LIMIT};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= SP_RESET;
            lo_half   <= 16'h0;
            op_is_pop <= 1'b0;
        end else begin
            state     <= state_nxt;
            sp        <= sp_nxt;
            lo_half   <= lo_half_nxt;
            op_is_pop <= op_is_pop_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sp_nxt        = sp;
        lo_half_nxt   = lo_half;
        op_is_pop_nxt = op_is_pop;
        o_mem_addr    = '0;
        o_mem_rd      = 1'b0;
        o_mem_wr      = 1'b0;
        o_mem_wdata   = 16'h0;
        o_rdata       = 16'h0;
        o_pc          = 32'h0;
        o_pc_valid    = 1'b0;
        o_stall       = 1'b0;
        o_stack_exc   = 1'b0;

        // rst gates the decode so every output is quiet while reset is held,
        // even if the upstream buffer still presents a live op.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (i_valid && !i_flush) begin
                        case (i_op)
                            OP_LOAD: begin
                                o_mem_rd   = 1'b1;
                                o_mem_addr = i_alu[ADDR_W-1:0];
                                o_rdata    = i_mem_rdata;
                            end
                            OP_STORE: begin
                                o_mem_wr    = 1'b1;
                                o_mem_addr  = i_alu[ADDR_W-1:0];
                                o_mem_wdata = i_read_data1;
                            end
                            OP_PUSH16, OP_PUSH32: begin
                                if (push_blk) begin
                                    // blocked first half stays in IDLE
                                    o_stack_exc = 1'b1;
                                end else begin
                                    o_mem_wr    = 1'b1;
                                    o_mem_addr  = sp;
                                    o_mem_wdata = (i_op == OP_PUSH32) ? i_pc[31:16]
                                                                      : i_read_data1;
                                    sp_nxt      = sp_dec;
                                    if (i_op == OP_PUSH32) begin
                                        state_nxt     = SECOND;
                                        op_is_pop_nxt = 1'b0;
                                        o_stall       = 1'b1;
                                    end
                                end
                            end
                            OP_POP16, OP_POP32: begin
                                o_mem_rd   = 1'b1;
                                o_mem_addr = sp_inc;
                                if (i_op == OP_POP16)
                                    o_rdata = i_mem_rdata;
                                if (pop_blk) begin
                                    o_stack_exc = 1'b1;
                                end else begin
                                    sp_nxt = sp_inc;
                                    if (i_op == OP_POP32) begin
                                        // low half sits nearer the top of stack
                                        lo_half_nxt   = i_mem_rdata;
                                        state_nxt     = SECOND;
                                        op_is_pop_nxt = 1'b1;
                                        o_stall       = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SECOND: begin
                    // upstream is frozen; valid/flush are ignored here
                    state_nxt = IDLE;
                    if (op_is_pop) begin
                        o_mem_rd   = 1'b1;
                        o_mem_addr = sp_inc;
                        o_pc       = {i_mem_rdata, lo_half};
                        o_pc_valid = 1'b1;
                        if (pop_blk)
                            o_stack_exc = 1'b1;
                        else
                            sp_nxt = sp_inc;
                    end else begin
                        if (push_blk) begin
                            o_stack_exc = 1'b1;
                        end else begin
                            o_mem_wr    = 1'b1;
                            o_mem_addr  = sp;
                            o_mem_wdata = i_pc[15:0];
                            sp_nxt      = sp_dec;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign o_sp = sp;

endmodule

// File: tb/tb_mem_stage_seq.sv
module tb_mem_stage_seq;

    localparam int          AW     = 12;
    localparam logic [11:0] SP_TOP = 12'hFFF;
    localparam logic [11:0] LIMIT  = 12'h800;

    logic        clk, rst;
    logic        i_valid, i_flush;
    logic [2:0]  i_op;
    logic [15:0] i_alu, i_read_data1, i_mem_rdata;
    logic [31:0] i_pc;
    logic [11:0] o_mem_addr, o_sp;
    logic        o_mem_rd, o_mem_wr, o_pc_valid, o_stall, o_stack_exc;
    logic [15:0] o_mem_wdata, o_rdata;
    logic [31:0] o_pc;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_seq #(.ADDR_W(AW), .SP_RESET(SP_TOP), .STACK_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush), .i_op(i_op),
        .i_alu(i_alu), .i_read_data1(i_read_data1), .i_pc(i_pc),
        .i_mem_rdata(i_mem_rdata), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
        .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata), .o_rdata(o_rdata),
        .o_pc(o_pc), .o_pc_valid(o_pc_valid), .o_stall(o_stall), .o_sp(o_sp),
        .o_stack_exc(o_stack_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory: async read, write on posedge; cleared once at start
    logic [15:0] mem [4096];
    logic        mem_clr;
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
        end else if (o_mem_wr) begin
            mem[o_mem_addr] <= o_mem_wdata;
        end
    end

    // reference model state: plain word array and a stack pointer
    logic [15:0] ref_mem [4096];
    logic [11:0] m_sp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit push_blocked(input logic [11:0] sp);
`ifdef SP_BOUNDS_CHECK_EN
        return sp < LIMIT;
`else
        return (sp == 12'h0) && 1'b0;
`endif
    endfunction

    function automatic bit pop_blocked(input logic [11:0] sp);
`ifdef SP_BOUNDS_CHECK_EN
        return sp == SP_TOP;
`else
        return (sp == 12'h0) && 1'b0;
`endif
    endfunction

    // one memory-stage cycle: inputs already driven; sample at negedge
    task automatic step(input bit e_rd, input bit e_wr, input logic [11:0] e_addr,
                        input logic [15:0] e_wdata, input bit chk_rdata,
                        input logic [15:0] e_rdata, input bit e_pcv,
                        input logic [31:0] e_pc, input bit e_stall, input bit e_exc);
        @(negedge clk);
        check("mem_rd", o_mem_rd, e_rd);
        check("mem_wr", o_mem_wr, e_wr);
        check("mem_addr", o_mem_addr, (e_rd || e_wr) ? e_addr : 12'h0);
        if (e_wr)      check("mem_wdata", o_mem_wdata, e_wdata);
        if (chk_rdata) check("rdata", o_rdata, e_rdata);
        check("pc_valid", o_pc_valid, e_pcv);
        if (e_pcv)     check("pc", o_pc, e_pc);
        check("stall", o_stall, e_stall);
        check("stack_exc", o_stack_exc, e_exc);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit valid, input bit flush, input logic [2:0] op,
                          input logic [15:0] alu, input logic [15:0] d,
                          input logic [31:0] pc, input bit sec_valid, input bit sec_flush);
        logic [11:0] a;
        logic [15:0] lo;
        i_valid = valid; i_flush = flush; i_op = op;
        i_alu = alu; i_read_data1 = d; i_pc = pc;
        a = alu[11:0];
        if (!valid || flush || op == 3'd0 || op == 3'd7) begin
            step(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 32'h0, 0, 0);
        end else begin
            case (op)
                3'd1: step(1, 0, a, 16'h0, 1, ref_mem[a], 0, 32'h0, 0, 0);
                3'd2: begin
                    step(0, 1, a, d, 0, 16'h0, 0, 32'h0, 0, 0);
                    ref_mem[a] = d;
                end
                3'd3: begin
                    if (push_blocked(m_sp)) begin
                        step(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 32'h0, 0, 1);
                    end else begin
                        step(0, 1, m_sp, d, 0, 16'h0, 0, 32'h0, 0, 0);
                        ref_mem[m_sp] = d;
                        m_sp = m_sp - 12'd1;
                    end
                end
                3'd4: begin
                    a = m_sp + 12'd1;
                    step(1, 0, a, 16'h0, 1, ref_mem[a], 0, 32'h0, 0, pop_blocked(m_sp));
                    if (!pop_blocked(m_sp)) m_sp = a;
                end
                3'd5: begin
                    if (push_blocked(m_sp)) begin
                        step(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 32'h0, 0, 1);
                    end else begin
                        step(0, 1, m_sp, pc[31:16], 0, 16'h0, 0, 32'h0, 1, 0);
                        ref_mem[m_sp] = pc[31:16];
                        m_sp = m_sp - 12'd1;
                        i_valid = sec_valid; i_flush = sec_flush;
                        if (push_blocked(m_sp)) begin
                            step(0, 0, 12'h0, 16'h0, 0, 16'h0, 0, 32'h0, 0, 1);
                        end else begin
                            step(0, 1, m_sp, pc[15:0], 0, 16'h0, 0, 32'h0, 0, 0);
                            ref_mem[m_sp] = pc[15:0];
                            m_sp = m_sp - 12'd1;
                        end
                    end
                end
                default: begin // POP32
                    a = m_sp + 12'd1;
                    if (pop_blocked(m_sp)) begin
                        step(1, 0, a, 16'h0, 0, 16'h0, 0, 32'h0, 0, 1);
                    end else begin
                        step(1, 0, a, 16'h0, 0, 16'h0, 0, 32'h0, 1, 0);
                        lo = ref_mem[a];
                        m_sp = a;
                        i_valid = sec_valid; i_flush = sec_flush;
                        a = m_sp + 12'd1;
                        step(1, 0, a, 16'h0, 0, 16'h0, 1, {ref_mem[a], lo}, 0,
                             pop_blocked(m_sp));
                        if (!pop_blocked(m_sp)) m_sp = a;
                    end
                end
            endcase
        end
        check("sp", o_sp, m_sp);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0;
        mem_clr = 1'b1;
        rst = 1'b1;
        // a live op during reset must not leak to the outputs
        i_valid = 1'b1; i_flush = 1'b0; i_op = 3'd3;
        i_alu = 16'h0123; i_read_data1 = 16'hDEAD; i_pc = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sp", o_sp, SP_TOP);
        check("rst_wr", o_mem_wr, 1'b0);
        check("rst_rd", o_mem_rd, 1'b0);
        check("rst_addr", o_mem_addr, 12'h0);
        check("rst_wdata", o_mem_wdata, 16'h0);
        check("rst_stall", o_stall, 1'b0);
        check("rst_pcv", o_pc_valid, 1'b0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_rdata", o_rdata, 16'h0);
        check("rst_exc", o_stack_exc, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        m_sp = SP_TOP;

        // directed sequence
        run_op(1, 0, 3'd3, 16'h0, 16'hA5A5, 32'h0, 0, 0);           // PUSH16
        run_op(1, 0, 3'd4, 16'h0, 16'h0, 32'h0, 0, 0);              // POP16
        run_op(1, 0, 3'd5, 16'h0, 16'h0, 32'h1234_5678, 0, 0);      // PUSH32
        run_op(1, 0, 3'd6, 16'h0, 16'h0, 32'h0, 0, 0);              // POP32
        check("pop32_sp", o_sp, 12'hFFF);
        run_op(1, 1, 3'd1, 16'h0010, 16'h0, 32'h0, 0, 0);           // flushed LOAD
        run_op(1, 0, 3'd5, 16'h0010, 16'h0, 32'h9ABC_DEF0, 1, 1);   // flush in SECOND
        run_op(1, 0, 3'd6, 16'h0, 16'h0, 32'h0, 0, 1);              // back-to-back pop
        run_op(1, 0, 3'd2, 16'h0040, 16'h5A5A, 32'h0, 0, 0);        // STORE
        run_op(1, 0, 3'd1, 16'h0040, 16'h0, 32'h0, 0, 0);           // LOAD
        run_op(0, 0, 3'd3, 16'h0, 16'h7777, 32'h0, 0, 0);           // not valid
        run_op(1, 0, 3'd7, 16'h0, 16'h0, 32'h0, 0, 0);              // reserved

        // reset during SECOND of a PUSH32: second write must never happen
        i_valid = 1; i_flush = 0; i_op = 3'd5; i_pc = 32'h4321_BEEF;
        step(0, 1, m_sp, 16'h4321, 0, 16'h0, 0, 32'h0, 1, 0);
        ref_mem[m_sp] = 16'h4321;
        rst = 1'b1;
        #1;
        check("rstmid_stall", o_stall, 1'b0);
        check("rstmid_wr", o_mem_wr, 1'b0);
        check("rstmid_sp", o_sp, SP_TOP);
        @(posedge clk); #1;
        check("rstmid_no2nd", mem[12'hFFE], ref_mem[12'hFFE]);
        rst = 1'b0;
        m_sp = SP_TOP;
        run_op(1, 0, 3'd0, 16'h0, 16'h0, 32'h0, 0, 0);

`ifdef SP_BOUNDS_CHECK_EN
        run_op(1, 0, 3'd4, 16'h0, 16'h0, 32'h0, 0, 0);              // POP16 at top
        for (int i = 0; i < 2048; i++)
            run_op(1, 0, 3'd3, 16'h0, 16'(i), 32'h0, 0, 0);
        check("bound_sp", o_sp, 12'h7FF);
        run_op(1, 0, 3'd3, 16'h0, 16'hBAD0, 32'h0, 0, 0);           // blocked push
        for (int i = 0; i < 2048; i++)
            run_op(1, 0, 3'd4, 16'h0, 16'h0, 32'h0, 0, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            run_op(($urandom % 8) != 0, ($urandom % 6) == 0, 3'($urandom % 8),
                   16'($urandom), 16'($urandom), $urandom,
                   1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
